// File: rtl/term_pkg.sv
// Shared types and character constants for the text-terminal engine.
// Contents: controller state enum and the control-code values the
// engine interprets (backspace, line feed, carriage return, space).
package term_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_e;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

endpackage

// File: rtl/term_char_ram.sv
// Simple dual-port character RAM: one write port, one read port with a
// 1-cycle registered read. Written to map onto block RAM.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (sampled every cycle)
//   rdata_o  - read data, one cycle after raddr_i
module term_char_ram #(
  parameter int DEPTH  = 2560,
  parameter int CHAR_W = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [CHAR_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [CHAR_W-1:0]        rdata_o
);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [CHAR_W-1:0] rdata_q;

  // Write port. No reset so the array stays inferable as block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/term_grid_ctrl.sv
// Text-terminal engine: accepts a character stream, interprets BS/LF/CR,
// keeps a cursor, scrolls via a circular top-row pointer and serves
// per-pixel character lookups for the glyph stage.
// Ports:
//   pixel_clk_in / rst_in            - clock, synchronous active-high reset
//   char_in, char_valid_in, char_ready_out - character stream handshake
//   clear_in                         - one-cycle clear-screen pulse
//   hcount_in, vcount_in             - beam position
//   char_code_out, glyph_x_out, glyph_y_out, in_grid_out, cursor_here_out
//                                    - beam outputs, 2 cycles after beam
//   cursor_col_out, cursor_row_out   - cursor position (logical row)
module term_grid_ctrl
  import term_pkg::*;
#(
  parameter int COLS    = 64,
  parameter int ROWS    = 40,
  parameter int CHAR_W  = 8,
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 16
) (
  input  logic                       pixel_clk_in,
  input  logic                       rst_in,
  input  logic [CHAR_W-1:0]          char_in,
  input  logic                       char_valid_in,
  output logic                       char_ready_out,
  input  logic                       clear_in,
  input  logic [10:0]                hcount_in,
  input  logic [9:0]                 vcount_in,
  output logic [CHAR_W-1:0]          char_code_out,
  output logic [$clog2(GLYPH_W)-1:0] glyph_x_out,
  output logic [$clog2(GLYPH_H)-1:0] glyph_y_out,
  output logic                       in_grid_out,
  output logic                       cursor_here_out,
  output logic [$clog2(COLS)-1:0]    cursor_col_out,
  output logic [$clog2(ROWS)-1:0]    cursor_row_out
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int RW1   = RW + 1;
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int GXW   = $clog2(GLYPH_W);
  localparam int GYW   = $clog2(GLYPH_H);
  localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CH_SPACE);

  // Logical (row, col) to RAM address; rotation by top_row wraps with a
  // single compare-subtract since row and top are both below ROWS.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                               input logic [CW-1:0] col,
                                               input logic [RW-1:0] top);
    logic [RW:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= RW1'(ROWS)) begin
      sum = sum - RW1'(ROWS);
    end else begin
      sum = sum;
    end
    return AW'(sum) * AW'(COLS) + AW'(col);
  endfunction

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     top_q, top_d;
  logic [RW-1:0]     scroll_row_q, scroll_row_d;
  logic              ready_q;
  logic              adv_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [CHAR_W-1:0] wdata_s;

  // Control FSM: next state, cursor update and RAM write port.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    top_d        = top_q;
    scroll_row_d = scroll_row_q;
    adv_s        = 1'b0;
    we_s         = 1'b0;
    waddr_s      = '0;
    wdata_s      = SPACE;
    if (clear_in) begin
      // Clear wins over everything, including a pending character.
      state_d = CLEAR;
      cnt_d   = '0;
      row_d   = '0;
      col_d   = '0;
      top_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (char_valid_in && ready_q) begin
            case (char_in)
              CHAR_W'(CH_CR): col_d = '0;
              CHAR_W'(CH_LF): begin
                col_d = '0;
                adv_s = 1'b1;
              end
              CHAR_W'(CH_BS): begin
                if (col_q != '0) begin
                  col_d   = col_q - CW'(1);
                  we_s    = 1'b1;
                  waddr_s = cell_addr(row_q, col_q - CW'(1), top_q);
                end else if (row_q != '0) begin
                  row_d   = row_q - RW'(1);
                  col_d   = CW'(COLS - 1);
                  we_s    = 1'b1;
                  waddr_s = cell_addr(row_q - RW'(1), CW'(COLS - 1), top_q);
                end else begin
                  col_d = col_q;
                end
              end
              default: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(row_q, col_q, top_q);
                wdata_s = char_in;
                if (col_q == CW'(COLS - 1)) begin
                  col_d = '0;
                  adv_s = 1'b1;
                end else begin
                  col_d = col_q + CW'(1);
                end
              end
            endcase
            // Advancing past the last row rotates the screen instead.
            if (adv_s) begin
              if (row_q == RW'(ROWS - 1)) begin
                top_d        = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
                scroll_row_d = top_q;  // old top becomes the new bottom row
                cnt_d        = '0;
                state_d      = SCROLL;
              end else begin
                row_d = row_q + RW'(1);
              end
            end else begin
              row_d = row_d;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          we_s    = 1'b1;
          waddr_s = cnt_q;
          if (cnt_q == AW'(DEPTH - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        SCROLL: begin
          we_s    = 1'b1;
          waddr_s = AW'(scroll_row_q) * AW'(COLS) + cnt_q;
          if (cnt_q == AW'(COLS - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        default: begin
          state_d = CLEAR;
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          top_d   = '0;
        end
      endcase
    end
  end

  // Control state registers; ready is registered from the next state.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state_q      <= CLEAR;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      top_q        <= '0;
      scroll_row_q <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      top_q        <= top_d;
      scroll_row_q <= scroll_row_d;
      ready_q      <= (state_d == IDLE);
    end
  end

  // Video stage 0: beam cell, in-grid test and physical read address.
  logic [10:0]    beam_col_s;
  logic [9:0]     beam_row_s;
  logic           in_grid_s;
  logic           here_s;
  logic [AW-1:0]  raddr_s;
  logic [CHAR_W-1:0] rdata_s;

  assign beam_col_s = hcount_in >> GXW;
  assign beam_row_s = vcount_in >> GYW;
  assign in_grid_s  = (beam_col_s < 11'(COLS)) && (beam_row_s < 10'(ROWS));
  assign here_s     = in_grid_s && (beam_col_s[CW-1:0] == col_q)
                      && (beam_row_s[RW-1:0] == row_q);
  // Out-of-grid beams would form an address past the array; park at 0.
  assign raddr_s    = in_grid_s ? cell_addr(beam_row_s[RW-1:0], beam_col_s[CW-1:0], top_q)
                                : '0;

  term_char_ram #(
    .DEPTH  (DEPTH),
    .CHAR_W (CHAR_W)
  ) u_ram (
    .clk_i   (pixel_clk_in),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  logic              in_grid_p1_q, here_p1_q;
  logic [GXW-1:0]    gx_p1_q;
  logic [GYW-1:0]    gy_p1_q;
  logic              in_grid_q, here_q;
  logic [GXW-1:0]    gx_q;
  logic [GYW-1:0]    gy_q;
  logic [CHAR_W-1:0] code_q;

  // Video stages 1 and 2: side-band follows the RAM read, then all beam
  // outputs register together.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      in_grid_p1_q <= 1'b0;
      here_p1_q    <= 1'b0;
      gx_p1_q      <= '0;
      gy_p1_q      <= '0;
      in_grid_q    <= 1'b0;
      here_q       <= 1'b0;
      gx_q         <= '0;
      gy_q         <= '0;
      code_q       <= SPACE;
    end else begin
      in_grid_p1_q <= in_grid_s;
      here_p1_q    <= here_s;
      gx_p1_q      <= hcount_in[GXW-1:0];
      gy_p1_q      <= vcount_in[GYW-1:0];
      in_grid_q    <= in_grid_p1_q;
      here_q       <= here_p1_q;
      gx_q         <= gx_p1_q;
      gy_q         <= gy_p1_q;
      code_q       <= in_grid_p1_q ? rdata_s : SPACE;
    end
  end

  assign char_ready_out  = ready_q;
  assign char_code_out   = code_q;
  assign glyph_x_out     = gx_q;
  assign glyph_y_out     = gy_q;
  assign in_grid_out     = in_grid_q;
  assign cursor_here_out = here_q;
  assign cursor_col_out  = col_q;
  assign cursor_row_out  = row_q;

endmodule

// File: tb/tb_term_grid_ctrl.sv
// Directed self-checking bench for term_grid_ctrl (default parameters).
module tb_term_grid_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_s;
  logic        valid;
  logic        ready;
  logic        clear;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [7:0]  code;
  logic [2:0]  gx;
  logic [3:0]  gy;
  logic        in_grid;
  logic        here;
  logic [5:0]  cur_col;
  logic [5:0]  cur_row;

  int n_cmp = 0;
  int n_err = 0;
  int n;

  always #5 clk = ~clk;

  term_grid_ctrl dut (
    .pixel_clk_in    (clk),
    .rst_in          (rst),
    .char_in         (char_s),
    .char_valid_in   (valid),
    .char_ready_out  (ready),
    .clear_in        (clear),
    .hcount_in       (hcount),
    .vcount_in       (vcount),
    .char_code_out   (code),
    .glyph_x_out     (gx),
    .glyph_y_out     (gy),
    .in_grid_out     (in_grid),
    .cursor_here_out (here),
    .cursor_col_out  (cur_col),
    .cursor_row_out  (cur_row)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 3000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic send(input logic [7:0] c);
    int w;
    wait_ready(w);
    if (!ready) check_eq("send_ready_timeout", 32'(ready), 32'd1);
    char_s = c;
    valid  = 1'b1;
    tick();
    valid  = 1'b0;
  endtask

  task automatic beam(input int col, input int row);
    hcount = 11'(col * 8);
    vcount = 10'(row * 16);
    tick();
    tick();
  endtask

  task automatic check_cell(input string tag, input int col, input int row, input logic [7:0] exp);
    beam(col, row);
    check_eq(tag, 32'(code), 32'(exp));
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    check_eq({tag, "_row"}, 32'(cur_row), 32'(row));
    check_eq({tag, "_col"}, 32'(cur_col), 32'(col));
  endtask

  initial begin
    rst = 1'b1; char_s = 8'h00; valid = 1'b0; clear = 1'b0;
    hcount = 11'd0; vcount = 10'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_code", 32'(code), 32'h20);
    check_eq("rst_in_grid", 32'(in_grid), 32'd0);
    check_eq("rst_here", 32'(here), 32'd0);
    check_eq("rst_gx", 32'(gx), 32'd0);
    check_eq("rst_gy", 32'(gy), 32'd0);
    check_cursor("rst_cursor", 0, 0);

    // Initial clear takes ROWS*COLS cycles
    wait_ready(n);
    check_eq("clear_cycles", 32'(n), 32'd2560);
    check_cell("clr_cell_0_0", 0, 0, 8'h20);
    check_cell("clr_cell_63_39", 63, 39, 8'h20);
    check_cell("clr_cell_10_20", 10, 20, 8'h20);

    // Outside the grid
    hcount = 11'd512; vcount = 10'd0; tick(); tick();
    check_eq("out_x_in_grid", 32'(in_grid), 32'd0);
    check_eq("out_x_code", 32'(code), 32'h20);
    hcount = 11'd0; vcount = 10'd640; tick(); tick();
    check_eq("out_y_in_grid", 32'(in_grid), 32'd0);
    check_eq("out_y_here", 32'(here), 32'd0);

    // "AB"
    send(8'h41);
    send(8'h42);
    check_cursor("ab_cursor", 0, 2);
    beam(2, 0);
    check_eq("ab_here_on_cursor", 32'(here), 32'd1);
    check_eq("ab_space_at_cursor", 32'(code), 32'h20);
    hcount = 11'd0; vcount = 10'd0;
    tick();
    check_eq("lat_1cyc_old", 32'(code), 32'h20);
    tick();
    check_eq("lat_2cyc_new", 32'(code), 32'h41);
    check_eq("ab_in_grid", 32'(in_grid), 32'd1);
    check_eq("ab_not_here", 32'(here), 32'd0);
    hcount = 11'd13; vcount = 10'd9; tick(); tick();
    check_eq("ab_cell_1_0", 32'(code), 32'h42);
    check_eq("ab_gx", 32'(gx), 32'd5);
    check_eq("ab_gy", 32'(gy), 32'd9);

    // CR, then 64 'x' and 'y' wraps to row 1
    send(8'h0D);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 64; i++) send(8'h78);
    send(8'h79);
    check_cursor("wrap_cursor", 1, 1);
    check_cell("wrap_x_63_0", 63, 0, 8'h78);
    check_cell("wrap_y_0_1", 0, 1, 8'h79);

    // Backspace
    send(8'h08);
    check_cursor("bs1_cursor", 1, 0);
    check_cell("bs1_erased", 0, 1, 8'h20);
    send(8'h08);
    check_cursor("bs2_cursor", 0, 63);
    check_cell("bs2_erased", 63, 0, 8'h20);
    send(8'h0D);
    send(8'h08);
    check_cursor("bs_origin_cursor", 0, 0);
    check_cell("bs_origin_keep", 0, 0, 8'h78);

    // Fill down to the last row, then scroll
    send(8'h0A);
    send(8'h4D);
    for (int i = 0; i < 38; i++) send(8'h0A);
    send(8'h5A);
    check_cursor("bottom_cursor", 39, 1);
    send(8'h0A);
    wait_ready(n);
    check_eq("scroll_cycles", 32'(n), 32'd64);
    check_cursor("scroll_cursor", 39, 0);
    check_cell("scroll_row0_M", 0, 0, 8'h4D);
    check_cell("scroll_row0_col5", 5, 0, 8'h20);
    check_cell("scroll_row38_Z", 0, 38, 8'h5A);
    check_cell("scroll_bottom_5", 5, 39, 8'h20);
    check_cell("scroll_bottom_62", 62, 39, 8'h20);

    // Clear with a simultaneous character during SCROLL
    send(8'h0A);
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_scroll_ready", 32'(ready), 32'd0);
    clear = 1'b1; valid = 1'b1; char_s = 8'h51;
    tick();
    clear = 1'b0; valid = 1'b0;
    check_cursor("clr_cursor", 0, 0);
    check_eq("clr_ready_low", 32'(ready), 32'd0);
    wait_ready(n);
    check_eq("clr_restart_cycles", 32'(n), 32'd2560);
    check_cell("clr_no_Q", 0, 0, 8'h20);
    check_cell("clr_row38", 0, 38, 8'h20);
    check_cursor("clr_cursor_after", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/term_grid_ctrl.md
Name: term_grid_ctrl

Overview:
- Parametrised text-terminal engine; replaces the flat 40x64 bit grid with a full character-code grid.
- Accepts a character stream via valid/ready and interprets control codes.
- Maintains a cursor and scrolls with a circular row pointer.
- Serves per-pixel character lookups to the sprite/glyph stage in the HDMI pixel pipeline.

Parameters:
- COLS, 64, characters per row
- ROWS, 40, rows on screen
- CHAR_W, 8, bits per character code
- GLYPH_W, 8, glyph width in pixels (power of 2)
- GLYPH_H, 16, glyph height in pixels (power of 2)

Ports:
- pixel_clk_in  in  1  sole clock
- rst_in  in  1  synchronous active-high reset
- char_in  in  CHAR_W  incoming character or control code
- char_valid_in  in  1  char_in valid
- char_ready_out  out  1  engine can accept char_in
- clear_in  in  1  one-cycle pulse: clear screen
- hcount_in  in  11  beam x
- vcount_in  in  10  beam y
- char_code_out  out  CHAR_W  code of cell under beam
- glyph_x_out  out  $clog2(GLYPH_W)  pixel column within glyph
- glyph_y_out  out  $clog2(GLYPH_H)  pixel row within glyph
- in_grid_out  out  1  beam inside COLS*GLYPH_W x ROWS*GLYPH_H
- cursor_here_out  out  1  beam cell equals cursor cell
- cursor_col_out  out  $clog2(COLS)  cursor column
- cursor_row_out  out  $clog2(ROWS)  cursor logical row

Behaviour:
- Clock and reset: one clock, pixel_clk_in. Reset is synchronous and active-high on rst_in.
- Reset values: cursor (0,0), top_row 0, char_ready_out 0, char_code_out 0x20, glyph_x/y 0, in_grid_out 0, cursor_here_out 0. Reset enters CLEAR.
- Storage: ROWS*COLS x CHAR_W RAM. Physical row = (logical row + top_row) mod ROWS. No divider; wrap by compare-subtract.
- FSM states: IDLE, CLEAR, SCROLL. char_ready_out = (state==IDLE); it is registered from the next state.
- Accept: a character is accepted when char_valid_in & char_ready_out & !clear_in. The RAM write lands in the same cycle as acceptance.
- Printable code (anything other than 0x08, 0x0A, 0x0D): write at cursor, col+1. At col COLS-1: wrap to col 0, row+1.
- 0x0D: col 0.
- 0x0A: col 0, row+1.
- 0x08: if col>0, col-1 and write 0x20 there. If col==0 and row>0, go to (row-1, COLS-1) and write 0x20. At (0,0): no-op.
- Row advance from ROWS-1: do not advance. Instead top_row <= top_row+1 mod ROWS, cursor=(ROWS-1,0), enter SCROLL.
- SCROLL: writes 0x20 to the new bottom physical row, one cell per cycle, COLS cycles, then IDLE.
- CLEAR: writes 0x20 to all cells sequentially, ROWS*COLS cycles, then IDLE. Cursor and top_row are set to 0 on entry.
- clear_in: honoured in any state, including mid-SCROLL and mid-CLEAR, where it restarts CLEAR from cell 0. It beats a simultaneous char_valid_in; that char is not accepted.
- Video path latency: exactly 2 cycles from hcount_in/vcount_in to all beam outputs.
  - Stage 0: col = hcount>>log2(GLYPH_W), row = vcount>>log2(GLYPH_H), in-grid compare, physical address.
  - Stage 1: registered RAM read.
  - All beam outputs are aligned to each other.
- Outside grid: in_grid_out=0, char_code_out=0x20, cursor_here_out=0.
- During CLEAR/SCROLL the video path reads live RAM contents; partially cleared screens are permitted.
- Cursor outputs are registered and reflect the state after each accepted op.

Decomposition:
- Package term_pkg holds:
  - the state enum (IDLE, CLEAR, SCROLL);
  - constants CH_BS=8'h08, CH_LF=8'h0A, CH_CR=8'h0D, CH_SPACE=8'h20.
- Sub-module term_char_ram: simple dual-port RAM, one write port, one read port with 1-cycle registered read, parametrised by DEPTH and CHAR_W, inferable as BRAM.

Test Plan:
- Reset, then wait 2560 cycles: char_ready_out rises at cycle 2561; every cell reads 0x20 at the beam.
- Write "AB": beam at (0,0) gives char_code_out 0x41; beam at (8,0) gives 0x42, 2 cycles later; cursor=(0,2).
- Write 64 'x' then 'y': 'y' lands at row 1, col 0; cursor=(1,1).
- Fill to row 39, then send 0x0A:
  - ready stays low for 64 cycles;
  - old row 1 content now displays at beam row 0;
  - bottom row is all 0x20;
  - cursor=(39,0).
- 0x08 at (0,0): no change. 0x08 at (2,0): cursor=(1,63) and cell (1,63)=0x20.
- clear_in asserted with char_valid_in during SCROLL: char not accepted; CLEAR restarts; cursor=(0,0); ready after 2560 cycles.
